fighter_logic: RTL and testbench
================================

Name: fighter_logic

Overview:
Parametrised next-generation player controller for the fighting-game datapath. It handles per-player facing, horizontal movement and a neutral/directional attack FSM with configurable frame data. It adds hitstun with knockback and a registered attack hitbox for the collision unit. Two instances, one per player with mirrored FACE_LEFT, sit between the input decoder and the sprite renderer/collision logic.

Parameters:
SCREEN_W, 640, screen width in pixels
CHAR_W, 32, sprite width
CHAR_H, 60, sprite height
FLOOR_OFF, 40, floor offset from screen bottom
INIT_X, 304, reset x position
FACE_LEFT, 0, 0: forward = right; 1: forward = left
FWD_SPD, 3, forward pixels per frame
BAK_SPD, 2, backward pixels per frame
N_STARTUP / N_ACTIVE / N_RECOV, 5 / 2 / 16, neutral attack phase lengths (frames, ≥1)
D_STARTUP / D_ACTIVE / D_RECOV, 4 / 3 / 15, directional attack phase lengths (frames, ≥1)
HITSTUN_LEN, 12, hitstun frames (≥1)
KNOCKBACK, 2, pixels pushed backward per hitstun frame
HIT_REACH, 24, hitbox width in pixels

Ports:
clk_game  in  1  game-frame clock
reset  in  1  asynchronous, active-low reset
move_left_cmd_in  in  1  left held
move_right_cmd_in  in  1  right held
attack_cmd_in  in  1  attack button level
hit_in  in  1  one-cycle hit pulse from the collision unit
char_x_pos_out  out  10  sprite left x
char_y_pos_out  out  10  constant SCREEN_H−CHAR_H−FLOOR_OFF (480 based)
char_width_out  out  10  constant CHAR_W
char_height_out  out  10  constant CHAR_H
char_color_out_332  out  8  phase colour, RGB332
phase_out  out  3  0 idle, 1 startup, 2 active, 3 recovery, 4 hitstun
attack_active  out  1  phase_out==2
attack_dir_out  out  1  current/last attack is directional
hitbox_x_out  out  10  hitbox left x
hitbox_w_out  out  10  hitbox width; 0 when no hitbox

Behaviour:
- Reset (reset low, async): x=INIT_X, state IDLE, timer 0, prev_attack 0, dir latch 0, attack_dir_out 0, hitbox_x_out 0, hitbox_w_out 0. Colour is IDLE (0xFE).
- Forward = right if FACE_LEFT=0, otherwise left. Forward moves at FWD_SPD; backward moves at BAK_SPD.
- IDLE movement, one update per clk_game:
  - Both directions held, or neither held: no move.
  - Moves clamp to [0, SCREEN_W−CHAR_W].
  - No movement in any other state.
- Attack trigger = attack_cmd_in & ~prev_attack; prev_attack is registered every cycle.
- Directional latch = (left|right), registered each cycle while in IDLE, frozen otherwise.
- IDLE + trigger: go to STARTUP. Load timer = X_STARTUP−1, where X = D if latch else N. attack_dir_out = latch.
- STARTUP→ACTIVE→RECOVERY→IDLE:
  - Each phase lasts exactly its parameter in cycles: decrement the timer, transition at timer==0, loading the next phase's length−1.
  - Triggers outside IDLE are ignored.
- hit_in in any state (including mid-attack) has priority over everything:
  - Go to HITSTUN, timer = HITSTUN_LEN−1; the attack is cancelled.
  - hit_in during HITSTUN reloads the timer.
  - Same-cycle hit_in and trigger in IDLE: HITSTUN, no attack.
- HITSTUN:
  - Each cycle, x moves KNOCKBACK backward (away from forward), clamped.
  - At timer==0, go to IDLE.
  - The trigger edge is consumed and not queued.
- Hitbox is registered and valid only while the next state is ACTIVE, so it aligns with attack_active.
  - Facing right: x = char_x+CHAR_W, w = min(HIT_REACH, SCREEN_W−x).
  - Facing left: x = max(char_x−HIT_REACH, 0), w = char_x−x.
  - Otherwise w=0, x holds its last value.
- Colour is decoded combinationally from state: IDLE 0xFE, STARTUP 0x1F, ACTIVE 0xE0, RECOVERY 0x38, HITSTUN 0xFC.
- All arithmetic is 10-bit unsigned; clamp comparisons are done before subtraction to avoid wrap.

Optional Feature:
FIGHTER_INPUT_BUFFER_EN
- Defined: a trigger during the last 4 RECOVERY frames (timer ≤3) sets a buffer flag. On RECOVERY exit the FSM goes directly to STARTUP, using the latch value captured at the buffered press. The flag is cleared by hit_in or on use.
- Undefined: triggers outside IDLE are dropped, and the RECOVERY→IDLE transition is unconditional.

Decomposition:
- Package fighter_pkg holds:
  - state/phase localparams (3-bit encoding);
  - RGB332 colour constants;
  - screen constants (640x480).
- Natural sub-module: fighter_hitbox, the combinational facing-aware hitbox x/w computation with clipping, registered in the parent.

Test Plan:
- Reset low mid-ACTIVE → outputs immediately at reset values: x=304, phase 0, colour 0xFE, hitbox_w 0.
- Neutral press (no dir held, default params) → phase 1 for 5 cycles, 2 for 2, 3 for 16, then 0. attack_active high for exactly 2 cycles with hitbox_x=336, w=24.
- Right held then press with FACE_LEFT=1 → directional timing 4/3/15, attack_dir_out=1. Hitbox at x=char_x−24.
- x=606, hold right → x=608 then stays 608. x=1, hold left → 0. Both held → unchanged.
- hit_in during STARTUP at x=10 (FACE_LEFT=0) → phase 4 for 12 cycles, x steps 8,6,…,0 then clamps at 0. Then IDLE; no attack resumes.
- With FIGHTER_INPUT_BUFFER_EN: press at RECOVERY timer=2 → STARTUP on the cycle after RECOVERY ends. Without the macro → IDLE.

Source files
------------

// File: rtl/fighter_pkg.sv
// fighter_pkg: phase encoding, RGB332 phase colours, screen constants and clamped step helpers
package fighter_pkg;

    localparam int SCREEN_W_PX = 640;
    localparam int SCREEN_H_PX = 480;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STARTUP  = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_RECOVERY = 3'd3,
        ST_HITSTUN  = 3'd4
    } phase_t;

    localparam logic [7:0] COL_IDLE     = 8'hFE;
    localparam logic [7:0] COL_STARTUP  = 8'h1F;
    localparam logic [7:0] COL_ACTIVE   = 8'hE0;
    localparam logic [7:0] COL_RECOVERY = 8'h38;
    localparam logic [7:0] COL_HITSTUN  = 8'hFC;

    // Compare against the limit before adding so the sum never needs to exceed it
    function automatic logic [9:0] step_up(input logic [9:0] x, input logic [9:0] s, input logic [9:0] lim);
        return (x > lim - s) ? lim : x + s;
    endfunction

    // Compare before subtracting so the result never wraps below zero
    function automatic logic [9:0] step_down(input logic [9:0] x, input logic [9:0] s);
        return (x < s) ? 10'd0 : x - s;
    endfunction

    function automatic logic [7:0] phase_colour(input phase_t p);
        return p == ST_STARTUP  ? COL_STARTUP  :
               p == ST_ACTIVE   ? COL_ACTIVE   :
               p == ST_RECOVERY ? COL_RECOVERY :
               p == ST_HITSTUN  ? COL_HITSTUN  : COL_IDLE;
    endfunction

endpackage

// File: rtl/fighter_logic_if.sv
// fighter_logic_if: player command inputs and sprite/collision outputs of one fighter
interface fighter_logic_if;

    logic       move_left_cmd_in;
    logic       move_right_cmd_in;
    logic       attack_cmd_in;
    logic       hit_in;
    logic [9:0] char_x_pos_out;
    logic [9:0] char_y_pos_out;
    logic [9:0] char_width_out;
    logic [9:0] char_height_out;
    logic [7:0] char_color_out_332;
    logic [2:0] phase_out;
    logic       attack_active;
    logic       attack_dir_out;
    logic [9:0] hitbox_x_out;
    logic [9:0] hitbox_w_out;

    modport master (
        output move_left_cmd_in, move_right_cmd_in, attack_cmd_in, hit_in,
        input  char_x_pos_out, char_y_pos_out, char_width_out, char_height_out,
               char_color_out_332, phase_out, attack_active, attack_dir_out,
               hitbox_x_out, hitbox_w_out
    );

    modport slave (
        input  move_left_cmd_in, move_right_cmd_in, attack_cmd_in, hit_in,
        output char_x_pos_out, char_y_pos_out, char_width_out, char_height_out,
               char_color_out_332, phase_out, attack_active, attack_dir_out,
               hitbox_x_out, hitbox_w_out
    );

endinterface

// File: rtl/fighter_hitbox.sv
// fighter_hitbox: facing-aware hitbox placement in front of the sprite, clipped to the screen
module fighter_hitbox #(
    parameter int SCREEN_W  = 640,
    parameter int CHAR_W    = 32,
    parameter int HIT_REACH = 24,
    parameter int FACE_LEFT = 0
) (
    input  logic [9:0] char_x,
    output logic [9:0] hit_x,
    output logic [9:0] hit_w
);

    localparam logic [9:0] SW = 10'(SCREEN_W);
    localparam logic [9:0] CW = 10'(CHAR_W);
    localparam logic [9:0] HR = 10'(HIT_REACH);
    localparam bit         FL = (FACE_LEFT != 0);

    logic [9:0] front_x;
    logic [9:0] room;

    // Right-facing box starts at the sprite's right edge; left-facing box ends at its left edge
    always_comb begin
        front_x = char_x + CW;
        room    = SW - front_x;
        hit_x   = FL ? ((char_x < HR) ? 10'd0 : char_x - HR) : front_x;
        hit_w   = FL ? char_x - hit_x : ((room < HR) ? room : HR);
    end

endmodule

// File: rtl/fighter_logic.sv
// fighter_logic: per-player movement, attack/hitstun FSM and hitbox; FIGHTER_INPUT_BUFFER_EN enables recovery input buffering
module fighter_logic
    import fighter_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_PX,
    parameter int CHAR_W      = 32,
    parameter int CHAR_H      = 60,
    parameter int FLOOR_OFF   = 40,
    parameter int INIT_X      = 304,
    parameter int FACE_LEFT   = 0,
    parameter int FWD_SPD     = 3,
    parameter int BAK_SPD     = 2,
    parameter int N_STARTUP   = 5,
    parameter int N_ACTIVE    = 2,
    parameter int N_RECOV     = 16,
    parameter int D_STARTUP   = 4,
    parameter int D_ACTIVE    = 3,
    parameter int D_RECOV     = 15,
    parameter int HITSTUN_LEN = 12,
    parameter int KNOCKBACK   = 2,
    parameter int HIT_REACH   = 24
) (
    input logic            clk_game,
    input logic            reset,
    fighter_logic_if.slave io
);

    localparam logic [9:0] X_MAX = 10'(SCREEN_W - CHAR_W);
    localparam logic [9:0] X_INIT = 10'(INIT_X);
    localparam logic [9:0] FWD = 10'(FWD_SPD);
    localparam logic [9:0] BAK = 10'(BAK_SPD);
    localparam logic [9:0] KB = 10'(KNOCKBACK);
    localparam logic [9:0] N_S1 = 10'(N_STARTUP - 1);
    localparam logic [9:0] N_A1 = 10'(N_ACTIVE - 1);
    localparam logic [9:0] N_R1 = 10'(N_RECOV - 1);
    localparam logic [9:0] D_S1 = 10'(D_STARTUP - 1);
    localparam logic [9:0] D_A1 = 10'(D_ACTIVE - 1);
    localparam logic [9:0] D_R1 = 10'(D_RECOV - 1);
    localparam logic [9:0] HS1 = 10'(HITSTUN_LEN - 1);
    localparam bit         FL = (FACE_LEFT != 0);

    phase_t     state;
    logic [9:0] x, timer, hb_x, hb_w, hit_x, hit_w, x_idle, x_knock;
    logic       prev_attack, dir_latch, attack_dir, trig, held;

    assign held    = io.move_left_cmd_in | io.move_right_cmd_in;
    assign trig    = io.attack_cmd_in & ~prev_attack;
    assign x_idle  = !(io.move_left_cmd_in ^ io.move_right_cmd_in) ? x :
                     io.move_right_cmd_in ? step_up(x, FL ? BAK : FWD, X_MAX) :
                                            step_down(x, FL ? FWD : BAK);
    assign x_knock = FL ? step_up(x, KB, X_MAX) : step_down(x, KB);

`ifdef FIGHTER_INPUT_BUFFER_EN
    logic buf_flag, buf_dir, go_dir;
    assign go_dir = buf_flag ? buf_dir : held;
`endif

    fighter_hitbox #(
        .SCREEN_W (SCREEN_W),
        .CHAR_W   (CHAR_W),
        .HIT_REACH(HIT_REACH),
        .FACE_LEFT(FACE_LEFT)
    ) u_hitbox (
        .char_x(x),
        .hit_x (hit_x),
        .hit_w (hit_w)
    );

    // Movement, attack phases and hitstun; the hitbox is loaded whenever the next state is ACTIVE
    always_ff @(posedge clk_game or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            x           <= X_INIT;
            timer       <= '0;
            prev_attack <= 1'b0;
            dir_latch   <= 1'b0;
            attack_dir  <= 1'b0;
            hb_x        <= '0;
            hb_w        <= '0;
`ifdef FIGHTER_INPUT_BUFFER_EN
            buf_flag    <= 1'b0;
            buf_dir     <= 1'b0;
`endif
        end else begin
            prev_attack <= io.attack_cmd_in;
            hb_w        <= '0;
            if (state == ST_IDLE) dir_latch <= held;
            if (state == ST_HITSTUN) x <= x_knock;
            else if (state == ST_IDLE && !io.hit_in) x <= x_idle;
            if (io.hit_in) begin
                state <= ST_HITSTUN;
                timer <= HS1;
`ifdef FIGHTER_INPUT_BUFFER_EN
                buf_flag <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: if (trig) begin
                        state      <= ST_STARTUP;
                        timer      <= dir_latch ? D_S1 : N_S1;
                        attack_dir <= dir_latch;
                    end
                    ST_STARTUP: if (timer == 10'd0) begin
                        state <= ST_ACTIVE;
                        timer <= attack_dir ? D_A1 : N_A1;
                        hb_x  <= hit_x;
                        hb_w  <= hit_w;
                    end else timer <= timer - 10'd1;
                    ST_ACTIVE: if (timer == 10'd0) begin
                        state <= ST_RECOVERY;
                        timer <= attack_dir ? D_R1 : N_R1;
                    end else begin
                        timer <= timer - 10'd1;
                        hb_x  <= hit_x;
                        hb_w  <= hit_w;
                    end
`ifdef FIGHTER_INPUT_BUFFER_EN
                    ST_RECOVERY: if (timer == 10'd0 && (buf_flag || trig)) begin
                        state      <= ST_STARTUP;
                        timer      <= go_dir ? D_S1 : N_S1;
                        attack_dir <= go_dir;
                        buf_flag   <= 1'b0;
                    end else if (timer == 10'd0) state <= ST_IDLE;
                    else begin
                        timer <= timer - 10'd1;
                        if (trig && timer <= 10'd3 && !buf_flag) begin
                            buf_flag <= 1'b1;
                            buf_dir  <= held;
                        end
                    end
`else
                    ST_RECOVERY: if (timer == 10'd0) state <= ST_IDLE;
                    else timer <= timer - 10'd1;
`endif
                    ST_HITSTUN: if (timer == 10'd0) state <= ST_IDLE;
                    else timer <= timer - 10'd1;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign io.char_x_pos_out     = x;
    assign io.char_y_pos_out     = 10'(SCREEN_H_PX - CHAR_H - FLOOR_OFF);
    assign io.char_width_out     = 10'(CHAR_W);
    assign io.char_height_out    = 10'(CHAR_H);
    assign io.char_color_out_332 = phase_colour(state);
    assign io.phase_out          = state;
    assign io.attack_active      = (state == ST_ACTIVE);
    assign io.attack_dir_out     = attack_dir;
    assign io.hitbox_x_out       = hb_x;
    assign io.hitbox_w_out       = hb_w;

endmodule

// File: tb/tb_fighter_logic.sv
// tb_fighter_logic: directed scoreboard bench for two mirrored fighter_logic players
module tb_fighter_logic;

    localparam int F_X = 0, F_Y = 1, F_W = 2, F_H = 3, F_COL = 4;
    localparam int F_PH = 5, F_ACT = 6, F_DIR = 7, F_HBX = 8, F_HBW = 9;

    typedef struct {
        string tag;
        int    sel;
        int    exp;
    } exp_t;

    logic clk_game = 1'b0;
    logic reset = 1'b0;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   ph;
    logic [9:0] o0 [10];
    logic [9:0] o1 [10];

    always #5 clk_game = ~clk_game;

    fighter_logic_if p0();
    fighter_logic_if p1();

    fighter_logic #(.FACE_LEFT(0)) u_p0 (.clk_game(clk_game), .reset(reset), .io(p0));
    fighter_logic #(.FACE_LEFT(1)) u_p1 (.clk_game(clk_game), .reset(reset), .io(p1));

    assign o0 = '{p0.char_x_pos_out, p0.char_y_pos_out, p0.char_width_out, p0.char_height_out,
                  10'(p0.char_color_out_332), 10'(p0.phase_out), 10'(p0.attack_active),
                  10'(p0.attack_dir_out), p0.hitbox_x_out, p0.hitbox_w_out};
    assign o1 = '{p1.char_x_pos_out, p1.char_y_pos_out, p1.char_width_out, p1.char_height_out,
                  10'(p1.char_color_out_332), 10'(p1.phase_out), 10'(p1.attack_active),
                  10'(p1.attack_dir_out), p1.hitbox_x_out, p1.hitbox_w_out};

    function automatic int col(input int p);
        return p == 1 ? 'h1F : p == 2 ? 'hE0 : p == 3 ? 'h38 : p == 4 ? 'hFC : 'hFE;
    endfunction

    task automatic push(input string tag, input int pl, input int f, input int v);
        sb.push_back('{tag, pl * 16 + f, v});
    endtask

    task automatic exp_phase(input string tag, input int pl, input int p);
        push(tag, pl, F_PH, p);
        push(tag, pl, F_COL, col(p));
        push(tag, pl, F_ACT, (p == 2) ? 1 : 0);
    endtask

    task automatic check_all();
        exp_t e;
        logic [9:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (e.sel / 16 == 0) ? o0[e.sel % 16] : o1[e.sel % 16];
            checks++;
            assert (o === 10'(e.exp)) else begin
                errors++;
                $error("FAIL %s p%0d field%0d: observed=%0d expected=%0d", e.tag, e.sel / 16, e.sel % 16, o, e.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk_game);
        #1;
        check_all();
    endtask

    initial begin
        p0.move_left_cmd_in = 0; p0.move_right_cmd_in = 0; p0.attack_cmd_in = 0; p0.hit_in = 0;
        p1.move_left_cmd_in = 0; p1.move_right_cmd_in = 0; p1.attack_cmd_in = 0; p1.hit_in = 0;
        repeat (2) @(posedge clk_game);
        #1;
        for (int pl = 0; pl < 2; pl++) begin
            push("rst_x", pl, F_X, 304);
            exp_phase("rst_phase", pl, 0);
            push("rst_dir", pl, F_DIR, 0);
            push("rst_hbx", pl, F_HBX, 0);
            push("rst_hbw", pl, F_HBW, 0);
            push("rst_y", pl, F_Y, 380);
            push("rst_w", pl, F_W, 32);
            push("rst_h", pl, F_H, 60);
        end
        check_all();
        reset = 1'b1;

        p0.attack_cmd_in = 1;
        for (int k = 0; k < 24; k++) begin
            ph = k < 5 ? 1 : k < 7 ? 2 : k < 23 ? 3 : 0;
            exp_phase("neutral", 0, ph);
            push("neutral_hbw", 0, F_HBW, ph == 2 ? 24 : 0);
            if (ph == 2) push("neutral_hbx", 0, F_HBX, 336);
            push("neutral_dir", 0, F_DIR, 0);
            push("neutral_x", 0, F_X, 304);
            cyc();
            if (k == 0) p0.attack_cmd_in = 0;
        end

        p0.attack_cmd_in = 1;
        cyc();
        p0.attack_cmd_in = 0;
        repeat (4) cyc();
        exp_phase("pre_rst", 0, 2);
        push("pre_rst_hbw", 0, F_HBW, 24);
        cyc();
        reset = 1'b0;
        #2;
        push("async_rst_x", 0, F_X, 304);
        exp_phase("async_rst", 0, 0);
        push("async_rst_hbw", 0, F_HBW, 0);
        check_all();
        #1 reset = 1'b1;

        p1.move_right_cmd_in = 1;
        push("p1_back_x", 1, F_X, 306);
        cyc();
        p1.move_right_cmd_in = 0;
        p1.attack_cmd_in = 1;
        for (int k = 0; k < 23; k++) begin
            ph = k < 4 ? 1 : k < 7 ? 2 : k < 22 ? 3 : 0;
            exp_phase("dir", 1, ph);
            push("dir_flag", 1, F_DIR, 1);
            push("dir_x", 1, F_X, 306);
            push("dir_hbw", 1, F_HBW, ph == 2 ? 24 : 0);
            if (ph == 2) push("dir_hbx", 1, F_HBX, 282);
            cyc();
            if (k == 0) p1.attack_cmd_in = 0;
        end

        p0.move_left_cmd_in = 1;
        push("p0_back1", 0, F_X, 302);
        cyc();
        push("p0_back2", 0, F_X, 300);
        cyc();
        p0.move_left_cmd_in = 0;
        p0.move_right_cmd_in = 1;
        repeat (101) cyc();
        push("p0_pre_clamp", 0, F_X, 606);
        cyc();
        push("p0_clamp_hi", 0, F_X, 608);
        cyc();
        push("p0_clamp_hold", 0, F_X, 608);
        cyc();
        p0.move_left_cmd_in = 1;
        push("p0_both_held", 0, F_X, 608);
        cyc();
        p0.move_right_cmd_in = 0;
        repeat (298) cyc();
        push("p0_at_10", 0, F_X, 10);
        cyc();
        p0.move_left_cmd_in = 0;

        p1.move_right_cmd_in = 1;
        push("p1_r1", 1, F_X, 308);
        cyc();
        push("p1_r2", 1, F_X, 310);
        cyc();
        p1.move_right_cmd_in = 0;
        p1.move_left_cmd_in = 1;
        repeat (102) cyc();
        push("p1_at_1", 1, F_X, 1);
        cyc();
        push("p1_clamp_lo", 1, F_X, 0);
        cyc();
        push("p1_clamp_hold", 1, F_X, 0);
        cyc();
        p1.move_right_cmd_in = 1;
        push("p1_both_held", 1, F_X, 0);
        cyc();
        p1.move_left_cmd_in = 0;
        p1.move_right_cmd_in = 0;

        push("p0_idle_10", 0, F_X, 10);
        cyc();
        p0.attack_cmd_in = 1;
        exp_phase("hit_pre", 0, 1);
        cyc();
        p0.attack_cmd_in = 0;
        exp_phase("hit_pre2", 0, 1);
        cyc();
        p0.hit_in = 1;
        exp_phase("hit_enter", 0, 4);
        push("hit_enter_x", 0, F_X, 10);
        push("hit_enter_hbw", 0, F_HBW, 0);
        cyc();
        p0.hit_in = 0;
        for (int k = 1; k <= 12; k++) begin
            push("knock_x", 0, F_X, (10 - 2 * k) < 0 ? 0 : 10 - 2 * k);
            exp_phase("hitstun", 0, k < 12 ? 4 : 0);
            if (k == 3) p0.attack_cmd_in = 1;
            if (k == 4) p0.attack_cmd_in = 0;
            cyc();
        end
        repeat (3) begin
            exp_phase("no_resume", 0, 0);
            cyc();
        end

        p1.attack_cmd_in = 1;
        p1.hit_in = 1;
        exp_phase("hit_and_trig", 1, 4);
        push("hit_and_trig_dir", 1, F_DIR, 1);
        cyc();
        p1.attack_cmd_in = 0;
        p1.hit_in = 0;
        for (int k = 1; k <= 12; k++) begin
            push("p1_knock_x", 1, F_X, 2 * k);
            exp_phase("p1_hitstun", 1, k < 12 ? 4 : 0);
            cyc();
        end
        exp_phase("p1_after", 1, 0);
        cyc();

        p0.attack_cmd_in = 1;
        for (int k = 0; k < 25; k++) begin
            ph = k < 5 ? 1 : k < 7 ? 2 : k < 23 ? 3 : 0;
`ifdef FIGHTER_INPUT_BUFFER_EN
            if (k >= 23) ph = 1;
`endif
            exp_phase("buffer", 0, ph);
            if (ph == 2) begin
                push("buffer_hbx", 0, F_HBX, 32);
                push("buffer_hbw", 0, F_HBW, 24);
            end
            cyc();
            if (k == 0 || k == 21) p0.attack_cmd_in = 0;
            if (k == 20) p0.attack_cmd_in = 1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
